// File: rtl/shiftrow_pipe.sv
// Rijndael ShiftRows / InvShiftRows for Nb = 4, 6, 8 with one registered output stage
// and a skid register so in_ready comes straight from a flop.
module shiftrow_pipe #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_mode
);

    if (!((NB == 4) || (NB == 6) || (NB == 8)) || (W != 32 * NB)) begin : g_bad_nb
        $error("shiftrow_pipe: NB must be 4, 6 or 8 and W must equal 32*NB");
    end

    logic [W-1:0] fwd, inv, perm;

    // Byte s[r][c] lives at bit W-1-8*(4c+r); every source index is a compile-time constant.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int SH = (r == 0) ? 0 :
                            (r == 1) ? 1 :
                            (r == 2) ? ((NB == 8) ? 3 : 2) :
                                       ((NB == 8) ? 4 : 3);
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FS = (c + SH) % NB;
            localparam int IS = (c - SH + NB) % NB;
            assign fwd[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*FS+r) -: 8];
            assign inv[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*IS+r) -: 8];
        end
    end

    assign perm = in_mode ? inv : fwd;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         out_mode_q,  out_mode_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         skid_mode_q,  skid_mode_d;
    logic         in_ready_q,   in_ready_d;
    logic         acc, drain;

    always_comb begin
        acc          = in_valid & in_ready_q;
        drain        = out_valid_q & out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        // The skid is only ever filled while the output register is stalled, and acc
        // cannot coincide with a full skid because in_ready mirrors its emptiness.
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = perm;
                out_mode_d  = in_mode;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm;
            skid_mode_d  = in_mode;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mode_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

endmodule

// File: doc/shiftrow_pipe.md
SHIFTROW_PIPE -- requirements
Module: shiftrow_pipe

Interface
REQ-001 Parameter NB, default 4, meaning state columns (Rijndael Nb); legal values 4, 6, 8; any other value SHALL fail elaboration.
REQ-002 Parameter W, default 32*NB, meaning state width in bits; derived, never overridden.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  input beat valid.
REQ-006 Port in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port in_mode  input  1  0 = forward ShiftRows (left rotate), 1 = inverse ShiftRows (right rotate); sampled with in_data.
REQ-008 Port in_data  input  W  state in; byte s[r][c] at in_data[W-1-8*(4c+r) -: 8] (column-major, byte 0 at MSB).
REQ-009 Port out_valid  output  1  output beat valid.
REQ-010 Port out_ready  input  1  downstream accepts a beat.
REQ-011 Port out_data  output  W  permuted state, same byte layout as in_data.
REQ-012 Port out_mode  output  1  mode that produced out_data.

Function
REQ-013 Row offsets SHALL be C = {0,1,2,3} for NB=4 and NB=6, and C = {0,1,3,4} for NB=8.
REQ-014 Forward mode SHALL produce out s'[r][c] = s[r][(c + C[r]) mod NB].
REQ-015 Inverse mode SHALL produce out s'[r][c] = s[r][(c - C[r] + NB) mod NB].
REQ-016 Forward followed by inverse (either order) on the same state SHALL return the original state.
REQ-017 Permutation SHALL be computed combinationally on the input side and registered.
REQ-018 Latency SHALL be exactly 1 cycle: a beat accepted at edge k SHALL present out_valid=1 after edge k when no stall is pending.
REQ-019 A beat SHALL transfer on the input when in_valid & in_ready at a rising edge.
REQ-020 A beat SHALL transfer on the output when out_valid & out_ready at a rising edge.
REQ-021 Storage SHALL be one output register plus one skid register; 0, 1 or 2 beats held.
REQ-022 in_ready SHALL be driven from a flop only: 1 when the skid register is empty, else 0.
REQ-023 When the output register is full, out_ready=0 and a beat is accepted, that beat SHALL go to the skid register; in_ready SHALL be 0 the next cycle.
REQ-024 When out_ready=1 with the skid register full, the skid beat SHALL move to the output register at that edge; in_ready SHALL return to 1 the next cycle.
REQ-025 Simultaneous input accept and output drain with the skid register empty SHALL load the new beat directly into the output register; out_valid SHALL stay 1 (full throughput, 1 beat/cycle).
REQ-026 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-027 out_data and out_mode SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 in_mode SHALL be per-beat; consecutive beats with different modes SHALL each use their own mode.
REQ-029 in_data and in_mode SHALL be ignored when in_valid=0.

Reset
REQ-030 While rst=1: out_valid=0, in_ready=0, skid register empty, out_data=0, out_mode=0, asynchronously.
REQ-031 First rising edge after rst deasserts: in_ready SHALL be 1.
REQ-032 rst asserted mid-stream SHALL discard all held beats immediately; no beat SHALL emerge after reset releases.

Verification
REQ-033 NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230, out_ready=1 -> one cycle later out_valid=1, out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_mode=0.
REQ-034 NB=4, inverse, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_mode=1.
REQ-035 NB=8, forward, byte i = i (00..1f) -> column 0 of out_data = 00,05,0e,13 (rows 0..3); inverse of that result -> original 00..1f.
REQ-036 Stream 10 beats of alternating mode with out_ready=0 for cycles 3-6 -> in_ready falls to 0 once 2 beats are held; all 10 outputs in order with correct modes; out_data stable during the stall.
REQ-037 Continuous in_valid=1 and out_ready=1 for 8 cycles -> 8 outputs on 8 consecutive cycles, in_ready never 0.
REQ-038 Assert rst with 2 beats held -> out_valid=0 and in_ready=0 at once; after release in_ready=1 at the first edge, no stale output.
